// File: rtl/bcd_countdown_timer_pkg.sv
// Shared definitions for the MM:SS BCD countdown timer: state encoding,
// digit limits, BCD field positions and the load clamping helper.
package bcd_countdown_timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [3:0] DIG_MAX   = 4'd9;
    localparam logic [3:0] SEC_T_MAX = 4'd5;

    // LSB position of each BCD field inside the 16-bit time word
    localparam int MT_LSB = 12;
    localparam int MU_LSB = 8;
    localparam int ST_LSB = 4;
    localparam int SU_LSB = 0;

    // Force every field of a loaded time into its legal BCD range
    function automatic logic [15:0] clamp_time(input logic [15:0] t);
        logic [3:0] mt, mu, st, su;
        mt = t[MT_LSB +: 4];
        mu = t[MU_LSB +: 4];
        st = t[ST_LSB +: 4];
        su = t[SU_LSB +: 4];
        if (mt > DIG_MAX)   mt = DIG_MAX;
        if (mu > DIG_MAX)   mu = DIG_MAX;
        if (st > SEC_T_MAX) st = SEC_T_MAX;
        if (su > DIG_MAX)   su = DIG_MAX;
        return {mt, mu, st, su};
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// Single BCD digit decrementer with borrow; chained to form the MM:SS counter.
module bcd_digit_down #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic [3:0] digit,
    input  logic       borrow_in,
    output logic [3:0] next_digit,
    output logic       borrow_out
);

    // Decrement on borrow_in; a zero digit wraps to MAX and borrows onward
    always_comb begin
        next_digit = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == 4'd0) begin
                next_digit = MAX;
                borrow_out = 1'b1;
            end else begin
                next_digit = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Loadable MM:SS BCD countdown timer with prescaled one-second tick,
// pause/resume and a single-cycle expiry pulse.
module bcd_countdown_timer
    import bcd_countdown_timer_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int CNT_W    = 26
) (
    input  logic        Clk,
    input  logic        nReset,       // active-high asynchronous reset
    input  logic        Load,
    input  logic [15:0] LoadTime,
    input  logic        Start,
    input  logic        Pause,
    output logic [15:0] PresentTime,
    output logic        Running,
    output logic        Expired,
    output state_e      state_dbg
);

    state_e             state_q, state_d;
    logic [15:0]        time_q, time_d;
    logic [CNT_W-1:0]   presc_q, presc_d;
    logic               running_q, running_d;
    logic               expired_q, expired_d;

    logic               tick;
    logic [15:0]        dec_time;
    logic               su_borrow, st_borrow, mu_borrow, mt_borrow;

    assign tick = (state_q == RUN) && (presc_q == CNT_W'(TICK_DIV - 1));

    // Ripple-borrow chain; the seconds-units digit is decremented by the tick
    bcd_digit_down #(.MAX(DIG_MAX)) u_su (
        .digit(time_q[SU_LSB +: 4]), .borrow_in(tick),
        .next_digit(dec_time[SU_LSB +: 4]), .borrow_out(su_borrow)
    );
    bcd_digit_down #(.MAX(SEC_T_MAX)) u_st (
        .digit(time_q[ST_LSB +: 4]), .borrow_in(su_borrow),
        .next_digit(dec_time[ST_LSB +: 4]), .borrow_out(st_borrow)
    );
    bcd_digit_down #(.MAX(DIG_MAX)) u_mu (
        .digit(time_q[MU_LSB +: 4]), .borrow_in(st_borrow),
        .next_digit(dec_time[MU_LSB +: 4]), .borrow_out(mu_borrow)
    );
    bcd_digit_down #(.MAX(DIG_MAX)) u_mt (
        .digit(time_q[MT_LSB +: 4]), .borrow_in(mu_borrow),
        .next_digit(dec_time[MT_LSB +: 4]), .borrow_out(mt_borrow)
    );

    // Next-state logic; priority is Load > Pause > Start
    always_comb begin
        state_d   = state_q;
        time_d    = time_q;
        presc_d   = presc_q;
        expired_d = 1'b0;
        if (Load) begin
            time_d  = clamp_time(LoadTime);
            state_d = IDLE;
            presc_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!Pause && Start && (time_q != 16'h0000)) begin
                        state_d = RUN;
                        presc_d = '0;
                    end
                end
                RUN: begin
                    if (tick) begin
                        presc_d = '0;
                        // A borrow out of the minutes tens would be an underflow;
                        // it cannot happen from a nonzero count, but pin to 0000.
                        if (mt_borrow || (dec_time == 16'h0000)) begin
                            time_d    = 16'h0000;
                            state_d   = DONE;
                            expired_d = 1'b1;
                        end else begin
                            time_d = dec_time;
                            if (Pause) state_d = PAUSED;
                        end
                    end else if (Pause) begin
                        state_d = PAUSED;
                    end else begin
                        presc_d = presc_q + CNT_W'(1);
                    end
                end
                PAUSED: begin
                    if (!Pause && Start) state_d = RUN;
                end
                DONE: begin
                    state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
        running_d = (state_d == RUN);
    end

    // State, count, prescaler and registered outputs
    always_ff @(posedge Clk or posedge nReset) begin
        if (nReset) begin
            state_q   <= IDLE;
            time_q    <= 16'h0000;
            presc_q   <= '0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            expired_q <= expired_d;
        end
    end

    assign PresentTime = time_q;
    assign Running     = running_q;
    assign Expired     = expired_q;
    assign state_dbg   = state_q;

endmodule
